// File: rtl/apb_ucpd_pkg.sv
// rtl/apb_ucpd_pkg.sv - shared constants, state encoding and 4b5b encoder for the UCPD transmitter
//
// Purpose: 4b5b data table, USB-PD K-codes and the transmit FSM state type.
// Ports:   none (package).
package apb_ucpd_pkg;

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_EOP   = 5'b01101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_EOP      = 3'd3,
    ST_TAIL     = 3'd4
  } tx_state_e;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] sym;
    case (nib)
      4'h0: sym = 5'b11110;
      4'h1: sym = 5'b01001;
      4'h2: sym = 5'b10100;
      4'h3: sym = 5'b10101;
      4'h4: sym = 5'b01010;
      4'h5: sym = 5'b01011;
      4'h6: sym = 5'b01110;
      4'h7: sym = 5'b01111;
      4'h8: sym = 5'b10010;
      4'h9: sym = 5'b10011;
      4'hA: sym = 5'b10110;
      4'hB: sym = 5'b10111;
      4'hC: sym = 5'b11010;
      4'hD: sym = 5'b11011;
      4'hE: sym = 5'b11100;
      default: sym = 5'b11101;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/apb_ucpd_bmc_line.sv
// rtl/apb_ucpd_bmc_line.sv - BMC half-bit phase and line level flops
//
// Purpose: produces the biphase-mark line level, one step per strobe.
// Ports:
//   clk_i        kernel clock
//   rst_i        synchronous active-high reset
//   bit_i        bit value, sampled on the strobe that starts a bit
//   strobe_i     advance one half-bit
//   force_low_i  drive the line to 0 and return to the bit-start phase
//   bmc_out_o    line level
//   mid_o        1 when the next strobe is the mid-bit half
module apb_ucpd_bmc_line (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bit_i,
  input  logic strobe_i,
  input  logic force_low_i,
  output logic bmc_out_o,
  output logic mid_o
);

  logic level_q;
  logic mid_q;
  logic bit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      mid_q   <= 1'b0;
      bit_q   <= 1'b0;
    end else if (force_low_i) begin
      level_q <= 1'b0;
      mid_q   <= 1'b0;
    end else if (strobe_i) begin
      if (!mid_q) begin
        // Every bit starts with a transition; the bit value decides the mid-bit one.
        level_q <= ~level_q;
        bit_q   <= bit_i;
        mid_q   <= 1'b1;
      end else begin
        if (bit_q) level_q <= ~level_q;
        mid_q <= 1'b0;
      end
    end
  end

  assign bmc_out_o = level_q;
  assign mid_o     = mid_q;

endmodule

// File: rtl/apb_ucpd_bmc_tx.sv
// rtl/apb_ucpd_bmc_tx.sv - USB-PD BMC transmit line coder
//
// Purpose: sends preamble, 4b5b-coded items and an EOP K-code as BMC,
//          advancing one half-bit per hbit_tick.
// Ports:
//   clk_in, rst          kernel clock, synchronous active-high reset
//   hbit_tick            half-bit strobe
//   tx_data/tx_kcode/tx_last/tx_valid/tx_ready   item handshake (one-entry hold)
//   bmc_out, drive_en    line level and transmitter enable
//   busy, tx_done, tx_underrun                   status
module apb_ucpd_bmc_tx
  import apb_ucpd_pkg::*;
#(
  parameter logic [6:0] PREAMBLE_BITS = 7'd64,
  parameter logic [4:0] EOP_SYM       = K_EOP
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       hbit_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_kcode,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       bmc_out,
  output logic       drive_en,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [6:0] PRE_LAST = PREAMBLE_BITS - 7'd1;

  tx_state_e  state_q, state_d;
  logic       drive_q, drive_d;
  logic [6:0] bitcnt_q, bitcnt_d;
  logic [2:0] bidx_q, bidx_d, nxt_idx;
  logic [4:0] sym_q, sym_d, sym2_q, sym2_d, load_sym;
  logic       has2_q, has2_d, last_q, last_d;
  logic       done_q, done_d, underrun_q, underrun_d;
  logic       hold_full_q, hold_k_q, hold_last_q;
  logic [7:0] hold_data_q;
  logic       load, xfer;
  logic       line_strobe, line_bit, line_force_low, line_mid;

  assign xfer     = tx_valid & ~hold_full_q;
  assign load_sym = hold_k_q ? hold_data_q[4:0] : enc_4b5b(hold_data_q[3:0]);

  always_comb begin
    state_d        = state_q;
    drive_d        = drive_q;
    bitcnt_d       = bitcnt_q;
    bidx_d         = bidx_q;
    sym_d          = sym_q;
    sym2_d         = sym2_q;
    has2_d         = has2_q;
    last_d         = last_q;
    done_d         = 1'b0;
    underrun_d     = 1'b0;
    load           = 1'b0;
    line_strobe    = 1'b0;
    line_bit       = 1'b0;
    line_force_low = 1'b0;
    nxt_idx        = bidx_q + 3'd1;
    if (hbit_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            state_d     = ST_PREAMBLE;
            drive_d     = 1'b1;
            bitcnt_d    = 7'd0;
            line_strobe = 1'b1;
          end
        end
        ST_PREAMBLE: begin
          line_strobe = 1'b1;
          if (!line_mid) begin
            if (bitcnt_q == PRE_LAST) begin
              load    = 1'b1;
              state_d = ST_DATA;
            end else begin
              bitcnt_d = bitcnt_q + 7'd1;
              line_bit = bitcnt_d[0];
            end
          end
        end
        ST_DATA: begin
          line_strobe = 1'b1;
          if (!line_mid) begin
            if (bidx_q != 3'd4) begin
              bidx_d   = nxt_idx;
              line_bit = sym_q[nxt_idx];
            end else if (has2_q) begin
              sym_d    = sym2_q;
              has2_d   = 1'b0;
              bidx_d   = 3'd0;
              line_bit = sym2_q[0];
            end else if (!last_q && hold_full_q) begin
              load = 1'b1;
            end else begin
              // Starved stream closes the packet exactly as a flagged last item would.
              underrun_d = ~last_q;
              state_d    = ST_EOP;
              sym_d      = EOP_SYM;
              bidx_d     = 3'd0;
              line_bit   = EOP_SYM[0];
            end
          end
        end
        ST_EOP: begin
          if (!line_mid && bidx_q == 3'd4) begin
            state_d        = ST_TAIL;
            line_force_low = 1'b1;
          end else begin
            line_strobe = 1'b1;
            if (!line_mid) begin
              bidx_d   = nxt_idx;
              line_bit = sym_q[nxt_idx];
            end
          end
        end
        ST_TAIL: begin
          state_d = ST_IDLE;
          drive_d = 1'b0;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load) begin
      sym_d    = load_sym;
      sym2_d   = enc_4b5b(hold_data_q[7:4]);
      has2_d   = ~hold_k_q;
      last_d   = hold_last_q;
      bidx_d   = 3'd0;
      line_bit = load_sym[0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drive_q     <= 1'b0;
      bitcnt_q    <= 7'd0;
      bidx_q      <= 3'd0;
      sym_q       <= 5'd0;
      sym2_q      <= 5'd0;
      has2_q      <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= 8'd0;
      hold_k_q    <= 1'b0;
      hold_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drive_q    <= drive_d;
      bitcnt_q   <= bitcnt_d;
      bidx_q     <= bidx_d;
      sym_q      <= sym_d;
      sym2_q     <= sym2_d;
      has2_q     <= has2_d;
      last_q     <= last_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      if (xfer) begin
        hold_full_q <= 1'b1;
        hold_data_q <= tx_data;
        hold_k_q    <= tx_kcode;
        hold_last_q <= tx_last;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  apb_ucpd_bmc_line u_line (
    .clk_i       (clk_in),
    .rst_i       (rst),
    .bit_i       (line_bit),
    .strobe_i    (line_strobe),
    .force_low_i (line_force_low),
    .bmc_out_o   (bmc_out),
    .mid_o       (line_mid)
  );

  assign tx_ready    = ~hold_full_q;
  assign drive_en    = drive_q;
  assign busy        = (state_q != ST_IDLE);
  assign tx_done     = done_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_apb_ucpd_bmc_tx.sv
// tb/tb_apb_ucpd_bmc_tx.sv - self-checking bench for the BMC transmit line coder
module tb_apb_ucpd_bmc_tx;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       hbit_tick = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_kcode = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, bmc_out, drive_en, busy, tx_done, tx_underrun;

  int checks = 0;
  int errors = 0;

  apb_ucpd_bmc_tx dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .hbit_tick   (hbit_tick),
    .tx_data     (tx_data),
    .tx_kcode    (tx_kcode),
    .tx_last     (tx_last),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bmc_out     (bmc_out),
    .drive_en    (drive_en),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  always #5 clk_in = ~clk_in;

  // Half-bit tick: high across exactly one rising edge, every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk_in);
      #1 hbit_tick = 1'b1;
      @(posedge clk_in);
      #1 hbit_tick = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation exceeded 1ms");
    $fatal(1, "watchdog");
  end

  // Line monitor: one sample per processed tick.
  logic tick_seen = 1'b0;
  logic lv_q[$];
  logic de_q[$];
  logic prev_de = 1'b0;
  int   rise_idx = -1;
  int   ur_idx = -1;
  int   done_cnt = 0;
  int   ur_cnt = 0;

  always @(posedge clk_in) tick_seen <= hbit_tick;

  always @(negedge clk_in) begin
    if (tick_seen) begin
      lv_q.push_back(bmc_out);
      de_q.push_back(drive_en);
      if (drive_en && !prev_de && rise_idx < 0) rise_idx = lv_q.size() - 1;
      prev_de = drive_en;
    end
    if (tx_done) done_cnt++;
    if (tx_underrun) begin
      ur_cnt++;
      ur_idx = lv_q.size() - 1;
    end
  end

  // Reference model
  typedef struct {
    logic       k;
    logic [7:0] d;
  } item_t;

  logic [4:0] tbl [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                           5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] eop_sym = 5'b01101;

  function automatic void build_model(input item_t its[$], output logic exp[$]);
    int   bits[$];
    logic lvl;
    logic [4:0] syms[$];
    exp.delete();
    for (int i = 0; i < 64; i++) bits.push_back(i % 2);
    foreach (its[i]) begin
      if (its[i].k) syms.push_back(its[i].d[4:0]);
      else begin
        syms.push_back(tbl[its[i].d[3:0]]);
        syms.push_back(tbl[its[i].d[7:4]]);
      end
    end
    syms.push_back(eop_sym);
    foreach (syms[s])
      for (int b = 0; b < 5; b++) bits.push_back(int'(syms[s][b]));
    lvl = 1'b0;
    foreach (bits[i]) begin
      lvl = ~lvl;
      exp.push_back(lvl);
      if (bits[i] != 0) lvl = ~lvl;
      exp.push_back(lvl);
    end
    exp.push_back(1'b0);
  endfunction

  // Index of first disagreement between the drive_en window and the model, -1 if none.
  function automatic int cmp_levels(input logic exp[$]);
    int n = 0;
    if (rise_idx < 0) return 0;
    for (int i = rise_idx; i < lv_q.size() && de_q[i]; i++) begin
      if (n >= exp.size() || lv_q[i] !== exp[n]) return n;
      n++;
    end
    return (n == exp.size()) ? -1 : n;
  endfunction

  function automatic int de_span();
    int n = 0;
    if (rise_idx < 0) return 0;
    for (int i = rise_idx; i < lv_q.size() && de_q[i]; i++) n++;
    return n;
  endfunction

  task automatic clear_mon();
    @(posedge clk_in);
    #2;
    lv_q.delete();
    de_q.delete();
    rise_idx = -1;
    ur_idx = -1;
    done_cnt = 0;
    ur_cnt = 0;
    prev_de = drive_en;
    @(negedge clk_in);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_item(input logic k, input logic [7:0] d, input logic l, output bit ok);
    int n = 0;
    tx_valid = 1'b1;
    tx_kcode = k;
    tx_data  = d;
    tx_last  = l;
    while (!tx_ready && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    @(negedge clk_in);
    tx_valid = 1'b0;
    ok = (n < 3000);
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    repeat (12) @(negedge clk_in);
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    bit ok;
    int n = 0;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    checks++;
    if ({bmc_out, drive_en, busy, tx_ready, tx_done, tx_underrun} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_state got %b expected 000100",
               {bmc_out, drive_en, busy, tx_ready, tx_done, tx_underrun});
    end
    clear_mon();
    push_item(1'b0, 8'h3C, 1'b1, ok);
    while (!(rise_idx >= 0 && lv_q.size() >= rise_idx + 135) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (!busy || n >= 3000) begin
      errors++;
      $display("FAIL reset_reach_data got busy=%b wait=%0d expected busy=1 in data", busy, n);
    end
    rst = 1'b1;
    @(negedge clk_in);
    rst = 1'b0;
    checks++;
    if ({bmc_out, drive_en, busy, tx_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_data got %b expected 0001", {bmc_out, drive_en, busy, tx_ready});
    end
    repeat (800) @(negedge clk_in);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done=%0d busy=%b expected done=0 busy=0", done_cnt, busy);
    end
  endtask

  task automatic test_kcode_sync1();
    bit ok, okd;
    item_t its[$];
    logic exp[$];
    int r;
    clear_mon();
    push_item(1'b1, 8'h18, 1'b1, ok);
    wait_done(okd);
    its.push_back('{k: 1'b1, d: 8'h18});
    build_model(its, exp);
    r = cmp_levels(exp);
    checks++;
    if (r != -1 || !ok) begin
      errors++;
      $display("FAIL sync1_levels got first diff at half-bit %0d accept=%0d expected none", r, ok);
    end
    checks++;
    if (de_span() != 149) begin
      errors++;
      $display("FAIL sync1_drive_ticks got %0d expected 149", de_span());
    end
    checks++;
    if (done_cnt != 1 || !okd) begin
      errors++;
      $display("FAIL sync1_done got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_byte_a5();
    bit ok, okd;
    item_t its[$];
    logic exp[$];
    logic [4:0] v;
    logic [7:0] dec;
    int r, j;
    clear_mon();
    push_item(1'b0, 8'hA5, 1'b1, ok);
    wait_done(okd);
    its.push_back('{k: 1'b0, d: 8'hA5});
    build_model(its, exp);
    r = cmp_levels(exp);
    checks++;
    if (r != -1 || !ok || !okd) begin
      errors++;
      $display("FAIL a5_levels got first diff at half-bit %0d expected none", r);
    end
    dec = 8'h00;
    for (int s = 0; s < 2; s++) begin
      v = 5'd0;
      for (int b = 0; b < 5; b++) begin
        j = rise_idx + 2 * (64 + 5 * s + b);
        if (rise_idx >= 0 && j + 1 < lv_q.size()) v[b] = (lv_q[j] != lv_q[j+1]);
      end
      for (int n = 0; n < 16; n++)
        if (tbl[n] == v) begin
          if (s == 0) dec[3:0] = 4'(n);
          else dec[7:4] = 4'(n);
        end
    end
    checks++;
    if (dec !== 8'hA5) begin
      errors++;
      $display("FAIL a5_decode got %h expected a5", dec);
    end
    checks++;
    if (ur_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL a5_status got underrun=%0d done=%0d expected 0 1", ur_cnt, done_cnt);
    end
  endtask

  task automatic test_back_pressure();
    bit ok, okall, okd;
    item_t its[$];
    logic exp[$];
    logic [7:0] d;
    int r;
    okall = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      its.push_back('{k: 1'b0, d: d});
      push_item(1'b0, d, (i == 3), ok);
      okall &= ok;
      if (i == 0) begin
        checks++;
        if (tx_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_fall got %b expected 0", tx_ready);
        end
      end
    end
    wait_done(okd);
    build_model(its, exp);
    r = cmp_levels(exp);
    checks++;
    if (r != -1 || !okall || !okd) begin
      errors++;
      $display("FAIL bp_levels got first diff at half-bit %0d accept=%0d expected none", r, okall);
    end
    checks++;
    if (done_cnt != 1 || ur_cnt != 0) begin
      errors++;
      $display("FAIL bp_status got done=%0d underrun=%0d expected 1 0", done_cnt, ur_cnt);
    end
  endtask

  task automatic test_underrun();
    bit ok, okd;
    item_t its[$];
    logic exp[$];
    logic [7:0] d;
    int r;
    clear_mon();
    d = 8'($urandom);
    push_item(1'b0, d, 1'b0, ok);
    wait_done(okd);
    checks++;
    if (ur_cnt != 1) begin
      errors++;
      $display("FAIL underrun_count got %0d expected 1", ur_cnt);
    end
    checks++;
    if (ur_idx - rise_idx != 148) begin
      errors++;
      $display("FAIL underrun_when got half-bit %0d expected 148", ur_idx - rise_idx);
    end
    its.push_back('{k: 1'b0, d: d});
    build_model(its, exp);
    r = cmp_levels(exp);
    checks++;
    if (r != -1 || !ok || !okd || done_cnt != 1) begin
      errors++;
      $display("FAIL underrun_levels got diff %0d done=%0d expected none done=1", r, done_cnt);
    end
  endtask

  task automatic test_simultaneous();
    bit ok, okall, okd;
    item_t its[$];
    logic exp[$];
    logic [7:0] a, b, c;
    int r, n;
    okall = 1'b1;
    n = 0;
    clear_mon();
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    push_item(1'b0, a, 1'b0, ok);
    okall &= ok;
    push_item(1'b0, b, 1'b0, ok);
    okall &= ok;
    // Tick 148 is the boundary that loads b from the hold.
    while (!(rise_idx >= 0 && lv_q.size() - rise_idx == 148 && hbit_tick) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b0 || n >= 3000) begin
      errors++;
      $display("FAIL sim_hold_full got ready=%b wait=%0d expected ready=0", tx_ready, n);
    end
    push_item(1'b1, 8'h11, 1'b1, ok);
    c = 8'h11;
    okall &= ok;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL sim_ready_after got %b expected 0", tx_ready);
    end
    wait_done(okd);
    its.push_back('{k: 1'b0, d: a});
    its.push_back('{k: 1'b0, d: b});
    its.push_back('{k: 1'b1, d: c});
    build_model(its, exp);
    r = cmp_levels(exp);
    checks++;
    if (r != -1 || !okall || !okd || ur_cnt != 0) begin
      errors++;
      $display("FAIL sim_levels got diff %0d underrun=%0d expected none 0", r, ur_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_kcode_sync1();
    test_byte_a5();
    test_back_pressure();
    test_underrun();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
